// File: rtl/pipe_tx_scrambler.sv
// PCIe transmit lane scrambler between the MAC TX datapath and the PIPE TX interface.
// The Gen3 128b/130b path is compiled in only when GEN3_SCRAMBLE_EN is defined.
module pipe_tx_scrambler (
  input  logic        clk,
  input  logic        reset,
  input  logic        turnOff,
  input  logic        gen3Mode,
  input  logic [5:0]  PIPEWIDTH,
  input  logic [23:0] seedValue,
  input  logic        txDataValid,
  input  logic        txStartBlock,
  input  logic [1:0]  txSyncHeader,
  input  logic [31:0] txData,
  input  logic [3:0]  txDataK,
  output logic [31:0] PIPETxData,
  output logic [3:0]  PIPETxDataK,
  output logic        PIPETxDataValid,
  output logic        PIPETxStartBlock,
  output logic [1:0]  PIPETxSyncHeader
);

  localparam logic [15:0] SEED16 = 16'hFFFF;
  localparam logic [7:0]  K_COM  = 8'hBC;
  localparam logic [7:0]  K_SKP  = 8'h1C;

  // Galois step for x^16+x^5+x^4+x^3+1
  function automatic logic [15:0] lfsr16_step(input logic [15:0] l);
    return {l[14:5], l[4] ^ l[15], l[3] ^ l[15], l[2] ^ l[15], l[1:0], l[15]};
  endfunction

  function automatic logic [23:0] byte16(input logic [7:0] d, input logic [15:0] l,
                                         input logic scr, input logic adv);
    logic [7:0]  o;
    logic [15:0] s;
    o = d;
    s = l;
    for (int b = 0; b < 8; b++) begin
      o[b] = scr ? (d[b] ^ s[15]) : d[b];
      s    = adv ? lfsr16_step(s) : s;
    end
    return {s, o};
  endfunction

  function automatic logic [2:0] lane_count(input logic [5:0] w);
    case (w)
      6'd8:    return 3'd1;
      6'd16:   return 3'd2;
      6'd32:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  logic [2:0]  lanes_s;
  logic [31:0] data_s;
  logic [7:0]  byte_s;
  logic [15:0] l16_s;
  logic [23:0] r16_s;
  logic [15:0] lfsr16_r;
  logic        upd_s;
  logic        unused_s;

`ifdef GEN3_SCRAMBLE_EN
  localparam logic [1:0] HDR_DATA = 2'b10;
  localparam logic [1:0] HDR_OS   = 2'b01;
  localparam logic [7:0] OS_SKP   = 8'hAA;
  localparam logic [7:0] OS_EIEOS = 8'h00;

  // Galois step for x^23+x^21+x^16+x^8+x^5+x^2+1
  function automatic logic [22:0] lfsr23_step(input logic [22:0] l);
    return {l[21], l[20] ^ l[22], l[19:16], l[15] ^ l[22], l[14:8], l[7] ^ l[22],
            l[6:5], l[4] ^ l[22], l[3:2], l[1] ^ l[22], l[0], l[22]};
  endfunction

  function automatic logic [30:0] byte23(input logic [7:0] d, input logic [22:0] l,
                                         input logic scr, input logic adv);
    logic [7:0]  o;
    logic [22:0] s;
    o = d;
    s = l;
    for (int b = 0; b < 8; b++) begin
      o[b] = scr ? (d[b] ^ s[22]) : d[b];
      s    = adv ? lfsr23_step(s) : s;
    end
    return {s, o};
  endfunction

  logic [22:0] lfsr23_r, l23_s;
  logic [30:0] r23_s;
  logic [3:0]  blk_byte_r, bb_s;
  logic [1:0]  blk_type_r, bt_s;
  logic        skp_blk_r, skp_s;
  logic        eieos_blk_r, eie_s;
  logic        mode_r;
  logic        seeded_r;

  assign unused_s = seedValue[23];
`else
  assign unused_s = ^{gen3Mode, seedValue};
`endif

  // Walk the active lanes in time order, each lane seeing the LFSR left by the previous one
  always_comb begin
    lanes_s = lane_count(PIPEWIDTH);
    data_s  = 32'h0000_0000;
    byte_s  = 8'h00;
    l16_s   = lfsr16_r;
    r16_s   = 24'h00_0000;
    upd_s   = txDataValid && !turnOff;
`ifdef GEN3_SCRAMBLE_EN
    l23_s   = seeded_r ? lfsr23_r : seedValue[22:0];
    r23_s   = 31'h0000_0000;
    bb_s    = blk_byte_r;
    bt_s    = blk_type_r;
    skp_s   = skp_blk_r;
    eie_s   = eieos_blk_r;
`endif
    for (int i = 0; i < 4; i++) begin
      byte_s = txData[8*i +: 8];
      if (3'(i) < lanes_s) begin
        if (!upd_s) begin
          data_s[8*i +: 8] = byte_s;
`ifdef GEN3_SCRAMBLE_EN
        end else if (mode_r) begin
          if ((i == 0) && txStartBlock) begin
            bb_s = 4'd0;
            bt_s = txSyncHeader;
          end else begin
            bb_s = bb_s;
          end
          // Ordered-set kind is decided by byte 0 and governs the rest of the block
          if (bb_s == 4'd0) begin
            skp_s = (bt_s == HDR_OS) && (byte_s == OS_SKP);
            eie_s = (bt_s == HDR_OS) && (byte_s == OS_EIEOS);
          end else begin
            skp_s = skp_s;
          end
          r23_s            = byte23(byte_s, l23_s, bt_s == HDR_DATA, !skp_s);
          data_s[8*i +: 8] = r23_s[7:0];
          l23_s            = (eie_s && (bb_s == 4'd15)) ? seedValue[22:0] : r23_s[30:8];
          bb_s             = bb_s + 4'd1;
`endif
        end else if (txDataK[i] && (byte_s == K_COM)) begin
          data_s[8*i +: 8] = byte_s;
          l16_s            = SEED16;
        end else begin
          r16_s            = byte16(byte_s, l16_s, !txDataK[i], !(txDataK[i] && (byte_s == K_SKP)));
          data_s[8*i +: 8] = r16_s[7:0];
          l16_s            = r16_s[23:8];
        end
      end else begin
        data_s[8*i +: 8] = 8'h00;
      end
    end
  end

  // Registered outputs, one clock behind the inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PIPETxData       <= 32'h0000_0000;
      PIPETxDataK      <= 4'h0;
      PIPETxDataValid  <= 1'b0;
      PIPETxStartBlock <= 1'b0;
      PIPETxSyncHeader <= 2'b00;
    end else begin
      PIPETxData       <= data_s;
      PIPETxDataK      <= txDataK;
      PIPETxDataValid  <= txDataValid;
      PIPETxStartBlock <= txStartBlock;
      PIPETxSyncHeader <= txSyncHeader;
    end
  end

  // Scrambler state; a mode change reloads the LFSR of the mode being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr16_r    <= SEED16;
`ifdef GEN3_SCRAMBLE_EN
      lfsr23_r    <= 23'h00_0000;
      seeded_r    <= 1'b0;
      mode_r      <= 1'b0;
      blk_byte_r  <= 4'd0;
      blk_type_r  <= 2'b10;
      skp_blk_r   <= 1'b0;
      eieos_blk_r <= 1'b0;
`endif
    end else begin
`ifdef GEN3_SCRAMBLE_EN
      seeded_r    <= 1'b1;
      mode_r      <= gen3Mode;
      lfsr16_r    <= (mode_r && !gen3Mode) ? SEED16 : l16_s;
      lfsr23_r    <= (!mode_r && gen3Mode) ? seedValue[22:0] : l23_s;
      blk_byte_r  <= bb_s;
      blk_type_r  <= bt_s;
      skp_blk_r   <= skp_s;
      eieos_blk_r <= eie_s;
`else
      lfsr16_r    <= l16_s;
`endif
    end
  end

endmodule

// File: doc/pipe_tx_scrambler.md
# pipe_tx_scrambler

Transmit-side scrambler for one PCIe lane, placed between the MAC transmit datapath and the PIPE TX interface of the PHY. It is the transmit counterpart of the lane descrambler. It XORs data symbols with the lane LFSR output and passes control/ordered-set symbols through. The LFSR is kept in lock-step with the link partner's descrambler, following the 8b/10b (Gen1/2) and 128b/130b (Gen3+) rules. Output is registered, one cycle after input.

## Interface
- No parameters; datapath width is runtime-selected by PIPEWIDTH.
- clk  in  1  PIPE PCLK.
- reset  in  1  asynchronous, active-low.
- turnOff  in  1  1 = bypass scrambling and freeze both LFSRs; data passes through (registered).
- gen3Mode  in  1  0 = 8b/10b rules, 16-bit LFSR; 1 = 128b/130b rules, 23-bit LFSR.
- PIPEWIDTH  in  6  active byte lanes: 8, 16 or 32 bits. Any other value gives zero output data.
- seedValue  in  24  Gen3 lane seed; bits [22:0] used, bit 23 ignored.
- txDataValid  in  1  input word valid. When 0, no LFSR or counter advance.
- txStartBlock  in  1  Gen3: this word carries byte 0 of a 130b block.
- txSyncHeader  in  2  Gen3 sync header: 2'b10 = data block, 2'b01 = ordered set. Sampled with txStartBlock.
- txData  in  32  input bytes; byte lane 0 = [7:0] = first in time.
- txDataK  in  4  per-byte K flag (Gen1/2 only).
- PIPETxData  out  32  scrambled data; inactive lanes = 0.
- PIPETxDataK  out  4  registered txDataK.
- PIPETxDataValid  out  1  registered txDataValid.
- PIPETxStartBlock  out  1  registered txStartBlock.
- PIPETxSyncHeader  out  2  registered txSyncHeader.

## Operation
- Active lanes are processed sequentially, lane 0 first, inside one cycle.
- Each lane sees the LFSR state left by the previous lane.
- Per-byte scramble step: 8 serial steps, LSB first.
  - Each step: out_bit = in_bit XOR lfsr MSB (lfsr[15] or lfsr[22]), then Galois shift.
  - The XOR is applied only if the byte is "scrambled". The shift happens only if the byte "advances".
- Gen1/2 (polynomial x^16+x^5+x^4+x^3+1, seed 16'hFFFF):
  - K byte 8'hBC (COM): unscrambled. LFSR becomes 16'hFFFF for the next byte.
  - K byte 8'h1C (SKP): unscrambled, no advance.
  - Other K bytes: unscrambled, advance.
  - D bytes: scrambled, advance.
- Gen3 (polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, seed = seedValue[22:0]):
  - A 4-bit byte counter (blkByte) tracks position within the 16-byte block.
  - txStartBlock forces blkByte = 0 at lane 0 and latches blkType from txSyncHeader.
  - blkByte increments per active lane, 15 wraps to 0.
  - Data block (blkType 2'b10): all bytes scrambled, advance.
  - Ordered set block (2'b01): bytes unscrambled, advance. Exceptions:
    - Byte 0 == 8'hAA (SKP OS) flags the block; the whole block does not advance.
    - Byte 0 == 8'h00 (EIEOS) flags the block; the LFSR is reloaded with seed after byte 15 of that block.
  - txDataK is ignored.
- A gen3Mode change takes effect at the next cycle. The LFSR for the new mode is reloaded with its seed on the 0→1 or 1→0 transition.
- turnOff = 1: PIPETxData = txData (masked to active lanes). LFSRs and blkByte hold.

## Timing
- Latency: exactly 1 clk from input to all outputs.
- Reset values:
  - All outputs 0.
  - LFSR16 = 16'hFFFF, LFSR23 = seedValue[22:0] as sampled at reset release (first clk edge).
  - blkByte = 0, blkType = 2'b10, block flags cleared.
- Reset asserted mid-block discards the block. After release, the first txStartBlock restarts counting.
- COM in lane k of a word: lanes >k of the same word use the reset seed.
- EIEOS reload takes effect for the first byte of the next block. This holds even when that byte is in the same word (8-bit lanes never share; 32-bit has no crossing since 16 is divisible by 4).
- txStartBlock only at lane 0; mid-word block starts are not supported.

## Configuration
- GEN3_SCRAMBLE_EN defined: the Gen3 path (23-bit LFSR, block counter, OS detection) is compiled in.
- GEN3_SCRAMBLE_EN undefined: the Gen3 logic is absent and gen3Mode is ignored (treated as 0). PIPETxStartBlock and PIPETxSyncHeader are still registered pass-throughs.

## Test plan
- Gen1, width 8: COM (K, 8'hBC) then D 8'h00 ×3 → outputs 8'hBC, 8'hFF, 8'h17, 8'hC0.
- Gen1, width 32: word {D00,D00,D00,K BC} → one cycle later PIPETxData = 32'hC017FFBC.
- Gen1, width 8: SKP 8'h1C inserted between D bytes after COM → the D stream still yields 8'hFF, 8'h17. The SKP byte is output as 8'h1C.
- Gen3, width 32, seed 24'h1DBFBC: a data block then an EIEOS block (byte0 8'h00), then a data block → the third block's scramble bytes equal the first block's.
- Gen3: SKP OS block (byte0 8'hAA) between two data blocks → the second data block continues the LFSR exactly where the first ended.
- turnOff = 1 with 32'h12345678, then reset asserted mid-block → output equals input after 1 clk; all outputs 0 during reset; LFSR16 = 16'hFFFF afterwards.
